// File: rtl/code_fetch_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  code_fetch_arbiter_pkg
//  Shared warp/code-memory sizing constants and the fetch FSM state type.
//  Revision: 1.0
// ============================================================================
package code_fetch_arbiter_pkg;

    localparam int DEPTH_WARP          = 2;
    localparam int NUM_WARP_DEFAULT    = 1 << DEPTH_WARP;
    localparam int CODE_MEM_ADDR_WIDTH = 32;
    localparam int CODE_MEM_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RSP   = 2'd3
    } fetch_state_e;

    function automatic int wid_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/code_fetch_arbiter_if.sv
`default_nettype none
// ============================================================================
//  code_fetch_arbiter_if
//  Fetch request, instruction response and code-memory read bundle.
//  Revision: 1.0
// ============================================================================
interface code_fetch_arbiter_if
    import code_fetch_arbiter_pkg::*;
#(
    parameter int NUM_WARP = NUM_WARP_DEFAULT,
    parameter int AW       = CODE_MEM_ADDR_WIDTH,
    parameter int DW       = CODE_MEM_DATA_WIDTH,
    parameter int WW       = wid_width(NUM_WARP)
);
    logic [NUM_WARP-1:0]    fetch_valid_i;
    logic [NUM_WARP*AW-1:0] fetch_addr_i;
    logic [NUM_WARP-1:0]    fetch_ready_o;
    logic [NUM_WARP-1:0]    flush_i;
    logic                   rsp_valid_o;
    logic [WW-1:0]          rsp_wid_o;
    logic [DW-1:0]          rsp_data_o;
    logic                   rsp_ready_i;
    logic                   code_mem_available_i;
    logic                   code_read_valid_o;
    logic [AW-1:0]          code_read_addr_o;
    logic                   code_read_ready_i;
    logic [DW-1:0]          code_read_data_i;

    // The arbiter itself is the slave; warps, consumer and memory form the master side.
    modport slave (
        input  fetch_valid_i, fetch_addr_i, flush_i, rsp_ready_i,
        input  code_mem_available_i, code_read_ready_i, code_read_data_i,
        output fetch_ready_o, rsp_valid_o, rsp_wid_o, rsp_data_o,
        output code_read_valid_o, code_read_addr_o
    );

    modport master (
        output fetch_valid_i, fetch_addr_i, flush_i, rsp_ready_i,
        output code_mem_available_i, code_read_ready_i, code_read_data_i,
        input  fetch_ready_o, rsp_valid_o, rsp_wid_o, rsp_data_o,
        input  code_read_valid_o, code_read_addr_o
    );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  rr_arbiter
//  Combinational round-robin picker; search begins one past ptr_i.
//  Revision: 1.0
// ============================================================================
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
)(
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    logic [IW-1:0] w_pos;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        w_pos   = '0;
        for (int k = 1; k <= N; k++) begin
            w_pos = IW'((int'(ptr_i) + k) % N);
            if (!valid_o && req_i[w_pos]) begin
                grant_o[w_pos] = 1'b1;
                idx_o          = w_pos;
                valid_o        = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/code_fetch_arbiter.sv
`default_nettype none
// ============================================================================
//  code_fetch_arbiter
//  Round-robin per-warp instruction fetch with a single outstanding code read.
//  Revision: 1.0
// ============================================================================
module code_fetch_arbiter
    import code_fetch_arbiter_pkg::*;
#(
    parameter int NUM_WARP = NUM_WARP_DEFAULT,
    parameter int AW       = CODE_MEM_ADDR_WIDTH,
    parameter int DW       = CODE_MEM_DATA_WIDTH
)(
    input  logic               clk,
    input  logic               rst,
    code_fetch_arbiter_if.slave bus
);

    localparam int WW = wid_width(NUM_WARP);

    fetch_state_e        state_q;
    logic [WW-1:0]       wid_q;
    logic [WW-1:0]       last_q;
    logic [AW-1:0]       addr_q;
    logic [DW-1:0]       data_q;
    logic                cancel_q;
    logic                read_valid_q;
    logic                rsp_valid_q;

    logic [NUM_WARP-1:0] w_req;
    logic [NUM_WARP-1:0] w_grant;
    logic [WW-1:0]       w_idx;
    logic                w_any;
    logic [AW-1:0]       w_sel_addr;
    logic                w_flush_mine;

    // A warp being flushed this cycle is not eligible for a grant.
    assign w_req        = bus.fetch_valid_i & ~bus.flush_i;
    assign w_flush_mine = bus.flush_i[wid_q];

    rr_arbiter #(
        .N  (NUM_WARP),
        .IW (WW)
    ) u_rr (
        .req_i   (w_req),
        .ptr_i   (last_q),
        .grant_o (w_grant),
        .idx_o   (w_idx),
        .valid_o (w_any)
    );

    always_comb begin
        w_sel_addr = '0;
        for (int w = 0; w < NUM_WARP; w++) begin
            if (w_idx == WW'(w)) begin
                w_sel_addr = bus.fetch_addr_i[w*AW +: AW];
            end
        end
    end

    assign bus.fetch_ready_o     = (state_q == ST_IDLE && !rst) ? w_grant : '0;
    assign bus.code_read_valid_o = read_valid_q;
    assign bus.code_read_addr_o  = addr_q;
    assign bus.rsp_valid_o       = rsp_valid_q;
    assign bus.rsp_wid_o         = wid_q;
    assign bus.rsp_data_o        = data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            wid_q        <= '0;
            last_q       <= WW'(NUM_WARP - 1);
            addr_q       <= '0;
            data_q       <= '0;
            cancel_q     <= 1'b0;
            read_valid_q <= 1'b0;
            rsp_valid_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cancel_q <= 1'b0;
                    if (w_any) begin
                        wid_q        <= w_idx;
                        last_q       <= w_idx;
                        addr_q       <= w_sel_addr;
                        read_valid_q <= 1'b1;
                        state_q      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Once memory has taken the read it must be drained, even if flushed.
                    if (bus.code_mem_available_i) begin
                        read_valid_q <= 1'b0;
                        cancel_q     <= w_flush_mine;
                        state_q      <= ST_WAIT;
                    end else if (w_flush_mine) begin
                        read_valid_q <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (bus.code_read_ready_i) begin
                        if (cancel_q || w_flush_mine) begin
                            cancel_q <= 1'b0;
                            state_q  <= ST_IDLE;
                        end else begin
                            data_q      <= bus.code_read_data_i;
                            rsp_valid_q <= 1'b1;
                            state_q     <= ST_RSP;
                        end
                    end else if (w_flush_mine) begin
                        cancel_q <= 1'b1;
                    end
                end
                ST_RSP: begin
                    if (bus.rsp_ready_i || w_flush_mine) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_code_fetch_arbiter.sv
`default_nettype none
// ============================================================================
//  tb_code_fetch_arbiter
//  Transaction-level reference model plus directed and random fetch traffic.
//  Revision: 1.0
// ============================================================================
module tb_code_fetch_arbiter;
    import code_fetch_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int WW = wid_width(N);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    code_fetch_arbiter_if #(.NUM_WARP(N), .AW(AW), .DW(DW)) bus ();

    code_fetch_arbiter #(.NUM_WARP(N), .AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: one transaction record (phase 0 = awaiting memory accept,
    // 1 = awaiting memory data, 2 = holding the response) plus the last granted warp.
    bit            model_on = 1'b0;
    bit            m_busy   = 1'b0;
    int            m_phase  = 0;
    int            m_wid    = 0;
    int            m_last   = N - 1;
    bit            m_cancel = 1'b0;
    logic [AW-1:0] m_addr   = '0;
    logic [DW-1:0] m_data   = '0;

    int            grant_log[$];
    int            rsp_wid_log[$];
    logic [DW-1:0] rsp_data_log[$];
    logic [AW-1:0] rd_addr_log[$];

    always @(negedge clk) begin
        if (model_on) begin
            logic [N-1:0] exp_ready;
            int           win;
            bit           fl;
            win = -1;
            if (!rst && !m_busy) begin
                for (int k = 1; k <= N; k++) begin
                    if (win < 0 && bus.fetch_valid_i[(m_last + k) % N] && !bus.flush_i[(m_last + k) % N])
                        win = (m_last + k) % N;
                end
            end
            exp_ready = (win >= 0) ? (N'(1) << win) : '0;
            chk("fetch_ready", bus.fetch_ready_o, exp_ready);
            chk("read_valid", bus.code_read_valid_o, m_busy && m_phase == 0);
            if (m_busy && m_phase == 0) chk("read_addr", bus.code_read_addr_o, m_addr);
            chk("rsp_valid", bus.rsp_valid_o, m_busy && m_phase == 2);
            if (m_busy && m_phase == 2) begin
                chk("rsp_wid", bus.rsp_wid_o, m_wid);
                chk("rsp_data", bus.rsp_data_o, m_data);
            end

            if (!rst) begin
                for (int w = 0; w < N; w++)
                    if (bus.fetch_ready_o[w] && bus.fetch_valid_i[w]) grant_log.push_back(w);
                if (bus.code_read_valid_o && bus.code_mem_available_i)
                    rd_addr_log.push_back(bus.code_read_addr_o);
                if (bus.rsp_valid_o && bus.rsp_ready_i) begin
                    rsp_wid_log.push_back(int'(bus.rsp_wid_o));
                    rsp_data_log.push_back(bus.rsp_data_o);
                end
            end

            fl = bus.flush_i[m_wid];
            if (rst) begin
                m_busy = 1'b0; m_cancel = 1'b0; m_last = N - 1;
            end else if (!m_busy) begin
                if (win >= 0) begin
                    m_busy = 1'b1; m_phase = 0; m_wid = win; m_last = win; m_cancel = 1'b0;
                    m_addr = bus.fetch_addr_i[win*AW +: AW];
                end
            end else if (m_phase == 0) begin
                if (bus.code_mem_available_i) begin
                    m_phase = 1; m_cancel = fl;
                end else if (fl) begin
                    m_busy = 1'b0;
                end
            end else if (m_phase == 1) begin
                if (bus.code_read_ready_i) begin
                    if (m_cancel || fl) m_busy = 1'b0;
                    else begin m_phase = 2; m_data = bus.code_read_data_i; end
                end else if (fl) begin
                    m_cancel = 1'b1;
                end
            end else begin
                if (bus.rsp_ready_i || fl) m_busy = 1'b0;
            end
        end
    end

    // Code memory behaviour: latency counted in WAIT cycles, optional stray ready pulses.
    bit            mem_pend      = 1'b0;
    int            mem_cnt       = 0;
    int            mem_lat       = 1;
    bit            mem_use_fixed = 1'b0;
    logic [DW-1:0] mem_fixed     = '0;
    bit            avail_auto    = 1'b0;
    int            avail_pct     = 100;
    bit            spurious      = 1'b0;
    int            overlap_err   = 0;

    task automatic tick();
        logic acc;
        @(negedge clk);
        #1;
        acc = bus.code_read_valid_o && bus.code_mem_available_i && !rst;
        @(posedge clk);
        #2;
        bus.code_read_ready_i = 1'b0;
        bus.code_read_data_i  = $urandom();
        if (acc) begin
            if (mem_pend) overlap_err++;
            mem_pend = 1'b1;
            mem_cnt  = ((mem_lat > 0) ? mem_lat : int'($urandom_range(1, 4))) - 1;
        end
        if (mem_pend) begin
            if (mem_cnt == 0) begin
                bus.code_read_ready_i = 1'b1;
                if (mem_use_fixed) bus.code_read_data_i = mem_fixed;
                mem_pend = 1'b0;
            end else begin
                mem_cnt--;
            end
        end else if (spurious && $urandom_range(0, 7) == 0) begin
            bus.code_read_ready_i = 1'b1;
        end
        if (avail_auto) bus.code_mem_available_i = ($urandom_range(0, 99) < avail_pct);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    int g0, r0, a0, cnt;
    int exp_order[6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        rst = 1'b1;
        bus.fetch_valid_i = '1;
        bus.fetch_addr_i = '0;
        bus.flush_i = '0;
        bus.rsp_ready_i = 1'b1;
        bus.code_mem_available_i = 1'b1;
        bus.code_read_ready_i = 1'b0;
        bus.code_read_data_i = '0;
        tick();
        model_on = 1'b1;
        tick();
        chk("rst_fetch_ready", bus.fetch_ready_o, 0);
        chk("rst_read_valid", bus.code_read_valid_o, 0);
        chk("rst_read_addr", bus.code_read_addr_o, 0);
        chk("rst_rsp_valid", bus.rsp_valid_o, 0);
        chk("rst_rsp_wid", bus.rsp_wid_o, 0);
        chk("rst_rsp_data", bus.rsp_data_o, 0);
        bus.fetch_valid_i = '0;
        rst = 1'b0;
        tick();

        // Single fetch, memory data three WAIT cycles later
        r0 = rsp_wid_log.size(); a0 = rd_addr_log.size();
        mem_lat = 3; mem_use_fixed = 1'b1; mem_fixed = 32'hDEAD;
        bus.fetch_addr_i[0 +: AW] = 32'h10;
        bus.fetch_valid_i = 4'b0001;
        tick();
        bus.fetch_valid_i = '0;
        repeat (10) tick();
        chk("t1_read_count", rd_addr_log.size() - a0, 1);
        if (rd_addr_log.size() > a0) chk("t1_read_addr", rd_addr_log[a0], 32'h10);
        chk("t1_rsp_count", rsp_wid_log.size() - r0, 1);
        if (rsp_wid_log.size() > r0) begin
            chk("t1_rsp_wid", rsp_wid_log[r0], 0);
            chk("t1_rsp_data", rsp_data_log[r0], 32'hDEAD);
        end

        // All warps requesting from reset: rotating grants
        do_reset();
        g0 = grant_log.size(); r0 = rsp_wid_log.size();
        mem_lat = 1; mem_use_fixed = 1'b0;
        for (int w = 0; w < N; w++) bus.fetch_addr_i[w*AW +: AW] = 32'h100 + w;
        bus.fetch_valid_i = '1;
        repeat (40) tick();
        bus.fetch_valid_i = '0;
        repeat (8) tick();
        chk("t2_enough_grants", (grant_log.size() - g0) >= 6, 1);
        chk("t2_enough_rsps", (rsp_wid_log.size() - r0) >= 6, 1);
        for (int i = 0; i < 6; i++) begin
            if (grant_log.size() > g0 + i) chk("t2_grant_order", grant_log[g0 + i], exp_order[i]);
            if (rsp_wid_log.size() > r0 + i) chk("t2_rsp_order", rsp_wid_log[r0 + i], exp_order[i]);
        end
        chk("t2_one_outstanding", overlap_err, 0);

        // Memory busy for five ISSUE cycles
        a0 = rd_addr_log.size();
        bus.fetch_addr_i[1*AW +: AW] = 32'h55;
        bus.code_mem_available_i = 1'b0;
        bus.fetch_valid_i = 4'b0010;
        tick();
        bus.fetch_valid_i = '0;
        cnt = 0;
        repeat (5) begin
            if (bus.code_read_valid_o && bus.code_read_addr_o == 32'h55) cnt++;
            tick();
        end
        chk("t3_hold_cycles", cnt, 5);
        bus.code_mem_available_i = 1'b1;
        repeat (8) tick();
        chk("t3_accepts", rd_addr_log.size() - a0, 1);
        if (rd_addr_log.size() > a0) chk("t3_addr", rd_addr_log[a0], 32'h55);

        // Flush warp 2 while its read is in memory
        g0 = grant_log.size(); r0 = rsp_wid_log.size();
        mem_lat = 4;
        bus.fetch_addr_i[2*AW +: AW] = 32'h200;
        bus.fetch_addr_i[3*AW +: AW] = 32'h300;
        bus.fetch_valid_i = 4'b1100;
        tick();
        tick();
        bus.flush_i = 4'b0100;
        tick();
        bus.flush_i = '0;
        cnt = 0;
        while (grant_log.size() - g0 < 2 && cnt < 30) begin
            tick();
            cnt++;
        end
        bus.fetch_valid_i = '0;
        repeat (12) tick();
        chk("t4_grant_count", grant_log.size() - g0, 2);
        if (grant_log.size() >= g0 + 2) begin
            chk("t4_first_grant", grant_log[g0], 2);
            chk("t4_next_grant", grant_log[g0 + 1], 3);
        end
        chk("t4_rsp_count", rsp_wid_log.size() - r0, 1);
        if (rsp_wid_log.size() > r0) chk("t4_rsp_wid", rsp_wid_log[r0], 3);

        // Consumer stalls for four cycles
        r0 = rsp_wid_log.size();
        mem_lat = 1; mem_use_fixed = 1'b1; mem_fixed = 32'hBEEF;
        bus.fetch_addr_i[0 +: AW] = 32'h20;
        bus.rsp_ready_i = 1'b0;
        bus.fetch_valid_i = 4'b0001;
        tick();
        bus.fetch_valid_i = '1;
        cnt = 0;
        while (!bus.rsp_valid_o && cnt < 10) begin
            tick();
            cnt++;
        end
        chk("t5_rsp_seen", bus.rsp_valid_o, 1);
        cnt = 0;
        repeat (4) begin
            if (bus.rsp_valid_o && bus.rsp_wid_o == 0 && bus.rsp_data_o == 32'hBEEF && bus.fetch_ready_o == 0)
                cnt++;
            tick();
        end
        chk("t5_stable_cycles", cnt, 4);
        bus.fetch_valid_i = '0;
        bus.rsp_ready_i = 1'b1;
        repeat (4) tick();
        chk("t5_rsp_count", rsp_wid_log.size() - r0, 1);
        if (rsp_wid_log.size() > r0) chk("t5_rsp_data", rsp_data_log[r0], 32'hBEEF);

        // Reset while a read is in memory; data lands afterwards
        r0 = rsp_wid_log.size();
        mem_lat = 4; mem_use_fixed = 1'b0;
        bus.fetch_addr_i[1*AW +: AW] = 32'h30;
        bus.fetch_valid_i = 4'b0010;
        tick();
        bus.fetch_valid_i = '0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (6) tick();
        chk("t6_no_rsp", rsp_wid_log.size() - r0, 0);
        chk("t6_idle_read", bus.code_read_valid_o, 0);
        chk("t6_idle_rsp", bus.rsp_valid_o, 0);
        g0 = grant_log.size();
        bus.fetch_valid_i = '1;
        tick();
        bus.fetch_valid_i = '0;
        chk("t6_grant_count", grant_log.size() - g0, 1);
        if (grant_log.size() > g0) chk("t6_next_grant", grant_log[g0], 0);
        repeat (10) tick();

        // Random traffic against the model
        avail_auto = 1'b1; avail_pct = 60; mem_lat = 0; spurious = 1'b1;
        repeat (3000) begin
            bus.fetch_valid_i = N'($urandom());
            for (int w = 0; w < N; w++) bus.fetch_addr_i[w*AW +: AW] = $urandom();
            bus.flush_i = ($urandom_range(0, 15) == 0) ? N'($urandom()) : '0;
            bus.rsp_ready_i = ($urandom_range(0, 3) != 0);
            tick();
        end
        bus.fetch_valid_i = '0;
        bus.flush_i = '0;
        bus.rsp_ready_i = 1'b1;
        repeat (20) tick();
        chk("rand_one_outstanding", overlap_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
